// File: rtl/count_run_ctrl.sv
// count_run_ctrl
// Run sequencer for an enable/clear counter. Each run clears the counter,
// then issues prescaled enable ticks until the counter reaches the
// terminal value. Supports one-shot and auto-reload runs, pause, stop,
// a one-cycle done pulse and a saturating tally of completed runs.
//
// Optional feature macro: COUNT_RUN_IRQ_EN
//   When defined, adds a sticky completion interrupt (irq) that is
//   cleared by irq_ack. A done pulse takes priority over a simultaneous
//   ack.
module count_run_ctrl #(
  parameter int BITS    = 4,
  parameter int PRESC_W = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cfg_we,
  input  logic [BITS-1:0]    cfg_term,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_reload,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [BITS-1:0]    cnt_q,
  output logic               cnt_en,
  output logic               cnt_clr_n,
  output logic               busy,
  output logic               done,
  output logic [7:0]         run_count
`ifdef COUNT_RUN_IRQ_EN
  ,
  input  logic               irq_ack,
  output logic               irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Staging copies written by the management side at any time
  logic [BITS-1:0]    r_term_stg;
  logic [PRESC_W-1:0] r_presc_stg;
  logic               r_reload_stg;

  // Active copies, frozen for the duration of a run
  logic [BITS-1:0]    r_term_a;
  logic [PRESC_W-1:0] r_presc_a;
  logic               r_reload_a;

  state_t             r_state;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic               r_cnt_clr_n;
  logic [7:0]         r_run_count;

  // Staging view with same-cycle bypass so a write alongside start is used
  logic [BITS-1:0]    w_term_stage;
  logic [PRESC_W-1:0] w_presc_stage;
  logic               w_reload_stage;
  logic               w_presc_wrap;
  logic               w_at_term;
  logic [7:0]         w_run_count_inc;

  assign w_term_stage    = cfg_we ? cfg_term   : r_term_stg;
  assign w_presc_stage   = cfg_we ? cfg_presc  : r_presc_stg;
  assign w_reload_stage  = cfg_we ? cfg_reload : r_reload_stg;
  assign w_presc_wrap    = (r_presc_cnt == r_presc_a);
  assign w_at_term       = (cnt_q == r_term_a);
  assign w_run_count_inc = (r_run_count == 8'd255) ? 8'd255 : (r_run_count + 8'd1);

  // Capture configuration writes into the staging registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_term_stg   <= {BITS{1'b0}};
      r_presc_stg  <= {PRESC_W{1'b0}};
      r_reload_stg <= 1'b0;
    end else if (cfg_we) begin
      r_term_stg   <= cfg_term;
      r_presc_stg  <= cfg_presc;
      r_reload_stg <= cfg_reload;
    end
  end

  // Run sequencer: state, prescaler, active config, counter clear and tally
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cnt_clr_n <= 1'b0;
      r_presc_cnt <= {PRESC_W{1'b0}};
      r_term_a    <= {BITS{1'b0}};
      r_presc_a   <= {PRESC_W{1'b0}};
      r_reload_a  <= 1'b0;
      r_run_count <= 8'd0;
    end else begin
      // Clear is only pulled low for the single ARM cycle
      r_cnt_clr_n <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state     <= S_ARM;
            r_run_count <= 8'd0;
            r_term_a    <= w_term_stage;
            r_presc_a   <= w_presc_stage;
            r_reload_a  <= w_reload_stage;
            r_cnt_clr_n <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ARM: begin
          r_presc_cnt <= {PRESC_W{1'b0}};
          if (stop) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_presc_wrap) begin
            r_presc_cnt <= {PRESC_W{1'b0}};
          end else begin
            r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
          end
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_at_term) begin
            r_state <= S_DONE;
          end else if (pause) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_HOLD: begin
          // Prescaler frozen so the tick phase resumes where it left off
          if (stop) begin
            r_state <= S_IDLE;
          end else if (!pause) begin
            r_state <= S_RUN;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_DONE: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else begin
            r_run_count <= w_run_count_inc;
            if (r_reload_a) begin
              r_state     <= S_ARM;
              r_term_a    <= w_term_stage;
              r_presc_a   <= w_presc_stage;
              r_reload_a  <= w_reload_stage;
              r_cnt_clr_n <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Enable is suppressed at the terminal value so the counter never passes it
  assign cnt_en    = (r_state == S_RUN) && !stop && w_presc_wrap && !w_at_term;
  assign done      = (r_state == S_DONE) && !stop;
  assign busy      = (r_state != S_IDLE);
  assign cnt_clr_n = r_cnt_clr_n;
  assign run_count = r_run_count;

`ifdef COUNT_RUN_IRQ_EN
  logic r_irq;

  // Sticky completion interrupt; a done pulse wins over a simultaneous ack
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_irq <= 1'b0;
    end else if (done) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed testbench for count_run_ctrl with a behavioural enable/clear counter.
module tb_count_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_term;
  logic [7:0] cfg_presc;
  logic       cfg_reload;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] cnt_q;
  logic       cnt_en;
  logic       cnt_clr_n;
  logic       busy;
  logic       done;
  logic [7:0] run_count;
`ifdef COUNT_RUN_IRQ_EN
  logic       irq_ack;
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_run_ctrl #(.BITS(4), .PRESC_W(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cfg_we    (cfg_we),
    .cfg_term  (cfg_term),
    .cfg_presc (cfg_presc),
    .cfg_reload(cfg_reload),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .busy      (busy),
    .done      (done),
    .run_count (run_count)
`ifdef COUNT_RUN_IRQ_EN
    ,
    .irq_ack   (irq_ack),
    .irq       (irq)
`endif
  );

  // Behavioural counter: enable, asynchronous active-low clear
  always_ff @(posedge clk or negedge cnt_clr_n) begin
    if (!cnt_clr_n) cnt_q <= 4'd0;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run with configuration written in the same cycle; returns in the ARM cycle
  task automatic launch(input logic [3:0] term, input logic [7:0] presc, input logic reload);
    @(negedge clk);
    cfg_we = 1'b1; cfg_term = term; cfg_presc = presc; cfg_reload = reload; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    #1;
    chk("arm_clr_n", cnt_clr_n, 0);
    chk("arm_busy", busy, 1);
    chk("arm_en", cnt_en, 0);
  endtask

  // Count RUN/HOLD cycles and ticks until done; returns in the DONE cycle
  task automatic measure(input int budget, input int p_at, input int p_len,
                         output int cyc, output int ticks, output int mask);
    cyc = -1; ticks = 0; mask = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      pause = (i >= p_at) && (i < p_at + p_len);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
      if (cnt_en) begin
        ticks++;
        mask = mask | (1 << i);
      end
    end
    pause = 1'b0;
  endtask

  initial begin
    int cyc, tk, mk, n_done, last, bad;
    rst = 1'b1; cfg_we = 1'b0; cfg_term = 4'd0; cfg_presc = 8'd0; cfg_reload = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
`ifdef COUNT_RUN_IRQ_EN
    irq_ack = 1'b0;
`endif

    // Reset state and release
    repeat (3) @(negedge clk);
    #1;
    chk("rst_clr_n", cnt_clr_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_done", done, 0);
    chk("rst_run_count", run_count, 0);
    chk("rst_q", cnt_q, 0);
    rst = 1'b0;
    #1;
    chk("rel_clr_n_low", cnt_clr_n, 0);
    @(negedge clk); #1;
    chk("rel_clr_n_high", cnt_clr_n, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (busy !== 1'b0 || cnt_en !== 1'b0 || run_count !== 8'd0 || cnt_clr_n !== 1'b1) bad++;
    end
    chk("idle_20_cycles", bad, 0);

    // term=3 presc=0 one-shot
    launch(4'd3, 8'd0, 1'b0);
    measure(20, 99, 0, cyc, tk, mk);
    chk("t3_run_len", cyc, 4);
    chk("t3_ticks", tk, 3);
    chk("t3_tick_mask", mk, 32'h7);
    chk("t3_q_done", cnt_q, 3);
    chk("t3_busy_done", busy, 1);
    @(negedge clk); #1;
    chk("t3_done_single", done, 0);
    chk("t3_busy_fall", busy, 0);
    chk("t3_run_count", run_count, 1);
    chk("t3_q_hold", cnt_q, 3);

    // term=2 presc=2: ticks on RUN cycles 2 and 5, run count cleared by start
    launch(4'd2, 8'd2, 1'b0);
    measure(30, 99, 0, cyc, tk, mk);
    chk("p2_run_len", cyc, 7);
    chk("p2_ticks", tk, 2);
    chk("p2_tick_mask", mk, 32'h24);
    @(negedge clk); #1;
    chk("p2_run_count", run_count, 1);

    // Same run with pause held 4 cycles starting at RUN cycle 3
    launch(4'd2, 8'd2, 1'b0);
    measure(30, 3, 4, cyc, tk, mk);
    chk("pause_run_len", cyc, 11);
    chk("pause_ticks", tk, 2);
    chk("pause_tick_mask", mk, 32'h204);
    chk("pause_q", cnt_q, 2);

    // Reload run, then stop exactly on a DONE cycle
    launch(4'd1, 8'd0, 1'b1);
    measure(10, 99, 0, cyc, tk, mk);
    chk("rl_run_len", cyc, 2);
    @(negedge clk); #1;
    chk("rl_rearm_clr_n", cnt_clr_n, 0);
    chk("rl_rearm_busy", busy, 1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    #1;
    chk("stop_on_done_pulse", done, 0);
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("stop_on_done_busy", busy, 0);
    chk("stop_on_done_count", run_count, 1);

    // 300 reload runs: done every 4 cycles (ARM, RUN, RUN, DONE), tally saturates
    launch(4'd1, 8'd0, 1'b1);
    n_done = 0; last = -1; bad = 0;
    for (int c = 0; c < 1400 && n_done < 300; c++) begin
      @(negedge clk); #1;
      if (done) begin
        if (last >= 0 && (c - last) != 4) bad++;
        last = c;
        n_done++;
      end
    end
    chk("sat_done_pulses", n_done, 300);
    chk("sat_done_period", bad, 0);
    @(negedge clk); #1;
    chk("sat_run_count", run_count, 255);
    chk("sat_busy", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("sat_stop_busy", busy, 0);
    chk("sat_count_kept", run_count, 255);

    // Stop mid-run at q=2 with term=5
    launch(4'd5, 8'd0, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk);
    stop = 1'b1;
    #1;
    chk("stop_q_at", cnt_q, 2);
    chk("stop_en", cnt_en, 0);
    chk("stop_done", done, 0);
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("stop_idle", busy, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("stop_q_hold", cnt_q, 2);
    chk("stop_no_count", run_count, 0);
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    chk("start_stop_idle", busy, 0);
    chk("start_stop_no_clr", cnt_clr_n, 1);
    chk("start_stop_q", cnt_q, 2);

    // term=0: done after a single RUN cycle with no ticks
    launch(4'd0, 8'd3, 1'b0);
    measure(10, 99, 0, cyc, tk, mk);
    chk("t0_run_len", cyc, 1);
    chk("t0_ticks", tk, 0);
    chk("t0_q", cnt_q, 0);
    @(negedge clk); #1;
    chk("t0_run_count", run_count, 1);

`ifdef COUNT_RUN_IRQ_EN
    chk("irq_set", irq, 1);
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    #1;
    chk("irq_ack_clear", irq, 0);
    launch(4'd0, 8'd0, 1'b0);
    @(negedge clk); #1;
    chk("irq_low_run", irq, 0);
    @(negedge clk);
    irq_ack = 1'b1;
    #1;
    chk("irq_done_with_ack", done, 1);
    @(negedge clk);
    irq_ack = 1'b0;
    #1;
    chk("irq_set_wins", irq, 1);
`endif

    // Reset mid-run: immediate idle and counter clear
    launch(4'd5, 8'd0, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_clr_n", cnt_clr_n, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_q", cnt_q, 0);
    chk("mrst_en", cnt_en, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("mrst_clr_n_rel", cnt_clr_n, 1);
    chk("mrst_run_count", run_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
